// File: rtl/lc3b_types.sv
// Shared types and constants for the SLC-3 memory interface.
package lc3b_types;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} mem_state_t;

  localparam logic MEM_ASSERT             = 1'b0;
  localparam int   MEM_DEFAULT_DEPTH_LOG2 = 10;

  function automatic logic addr_in_range(input logic [15:0] addr, input int depth_log2);
    return (addr >> depth_log2) == 16'h0000;
  endfunction

endpackage

// File: rtl/slc3_sram_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
module slc3_sram_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = MEM_DEFAULT_DEPTH_LOG2
) (
  input  logic                  Clk,
  input  logic                  wr_en,
  input  logic [1:0]            wr_be,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [15:0]           rd_data
);

  logic [15:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
      if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/slc3_sram_responder.sv
// SRAM responder for the SLC-3 CPU: strobe decode, read latency, one-shot write commit, preload.
// state     | meaning
// IDLE      | no transaction open; preloads accepted here
// RD_WAIT   | read latched, latency counter running
// RD_DRIVE  | read data registered onto Data_out
// WR_ACTIVE | write open, holding register tracks the bus
module slc3_sram_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = MEM_DEFAULT_DEPTH_LOG2,
  parameter int READ_LAT   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_valid,
  input  logic        Load_en,
  input  logic [15:0] Load_addr,
  input  logic [15:0] Load_data,
  output logic        Oob_err,
  output logic        Load_err
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);
  localparam mem_state_t RD_FIRST = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;

  mem_state_t state, state_nxt;
  logic [1:0]  lat_cnt, lat_cnt_nxt;
  logic [15:0] rd_addr_q, rd_addr_nxt;
  logic [15:0] hold_addr, hold_data;
  logic        hold_ub, hold_lb;

  logic rd_req, wr_req, addr_chg, commit, load_ok, oob_evt;
  logic wr_en;
  logic [1:0] wr_be;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [15:0] wr_data, rd_data, rd_word;

  assign rd_req   = (Mem_CE == MEM_ASSERT) && (Mem_WE != MEM_ASSERT) && (Mem_OE == MEM_ASSERT);
  assign wr_req   = (Mem_CE == MEM_ASSERT) && (Mem_WE == MEM_ASSERT);
  assign addr_chg = ADDR != rd_addr_q;
  assign commit   = (state == WR_ACTIVE) && !wr_req;
  assign load_ok  = Load_en && (state == IDLE) && (Mem_CE != MEM_ASSERT);

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    rd_addr_nxt = rd_addr_q;
    case (state)
      IDLE: begin
        if (rd_req) begin
          rd_addr_nxt = ADDR;
          lat_cnt_nxt = LAT_LOAD;
          state_nxt   = RD_FIRST;
        end else if (wr_req) begin
          state_nxt = WR_ACTIVE;
        end
      end
      RD_WAIT: begin
        if (!rd_req) begin
          state_nxt = IDLE;
        end else if (addr_chg) begin
          rd_addr_nxt = ADDR;
          lat_cnt_nxt = LAT_LOAD;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) state_nxt = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (!rd_req) begin
          state_nxt = IDLE;
        end else if (addr_chg) begin
          rd_addr_nxt = ADDR;
          lat_cnt_nxt = LAT_LOAD;
          state_nxt   = RD_FIRST;
        end
      end
      WR_ACTIVE: if (!wr_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Disabled lanes read back as zero bytes.
  always_comb begin
    rd_word = rd_data;
    if (Mem_UB != MEM_ASSERT) rd_word[15:8] = 8'h00;
    if (Mem_LB != MEM_ASSERT) rd_word[7:0]  = 8'h00;
  end

  assign oob_evt = ((state_nxt == RD_DRIVE) && !addr_in_range(ADDR, DEPTH_LOG2))
                || (commit && !addr_in_range(hold_addr, DEPTH_LOG2))
                || (load_ok && !addr_in_range(Load_addr, DEPTH_LOG2));

  // Reset gates the port so a write open at reset never lands.
  assign wr_en   = !Reset && ((commit && addr_in_range(hold_addr, DEPTH_LOG2))
                           || (load_ok && addr_in_range(Load_addr, DEPTH_LOG2)));
  assign wr_addr = commit ? hold_addr[DEPTH_LOG2-1:0] : Load_addr[DEPTH_LOG2-1:0];
  assign wr_data = commit ? hold_data : Load_data;
  assign wr_be   = commit ? {hold_ub == MEM_ASSERT, hold_lb == MEM_ASSERT} : 2'b11;

  slc3_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ADDR[DEPTH_LOG2-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      rd_addr_q  <= 16'h0000;
      hold_addr  <= 16'h0000;
      hold_data  <= 16'h0000;
      hold_ub    <= 1'b1;
      hold_lb    <= 1'b1;
      Data_out   <= 16'h0000;
      Data_valid <= 1'b0;
      Oob_err    <= 1'b0;
      Load_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      rd_addr_q  <= rd_addr_nxt;
      if (state_nxt == WR_ACTIVE) begin
        hold_addr <= ADDR;
        hold_data <= Data_in;
        hold_ub   <= Mem_UB;
        hold_lb   <= Mem_LB;
      end
      Data_valid <= state_nxt == RD_DRIVE;
      Data_out   <= ((state_nxt == RD_DRIVE) && addr_in_range(ADDR, DEPTH_LOG2)) ? rd_word : 16'h0000;
      Load_err   <= Load_en && !load_ok;
      if (oob_evt) Oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slc3_sram_responder.sv
// Bench for slc3_sram_responder: READ_LAT=1 and READ_LAT=3 instances on a shared bus,
// checked every cycle against a transaction-level memory model plus directed literal checks.
module tb_slc3_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [15:0] ADDR, Data_in, Load_addr, Load_data;
  logic        Load_en;
  logic [15:0] dout1, dout3;
  logic        dv1, dv3, oob1, oob3, lerr1, lerr3;

  int vectors = 0;
  int errors  = 0;

  always #5 Clk = ~Clk;

  slc3_sram_responder #(.DEPTH_LOG2(10), .READ_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
    .Data_out(dout1), .Data_valid(dv1), .Load_en(Load_en), .Load_addr(Load_addr),
    .Load_data(Load_data), .Oob_err(oob1), .Load_err(lerr1)
  );

  slc3_sram_responder #(.DEPTH_LOG2(10), .READ_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
    .Data_out(dout3), .Data_valid(dv3), .Load_en(Load_en), .Load_addr(Load_addr),
    .Load_data(Load_data), .Oob_err(oob3), .Load_err(lerr3)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a read phase is a run of consecutive read-request edges at one address;
  // data is valid once the run length reaches the latency. A write phase spans the
  // write-request edges and commits the last sampled bus at the edge that ends it.
  logic [15:0] mem_m [1024];
  int          rd_run;
  bit          wr_open;
  logic [15:0] last_addr, h_addr, h_data;
  logic        h_ub, h_lb;
  logic [15:0] e_dout1, e_dout3;
  logic        e_dv1, e_dv3, e_oob1, e_oob3, e_lerr;

  function automatic logic in_range(input logic [15:0] a);
    return a[15:10] == 6'd0;
  endfunction

  task automatic model_reset();
    rd_run = 0; wr_open = 0;
    e_dout1 = 0; e_dout3 = 0; e_dv1 = 0; e_dv3 = 0;
    e_oob1 = 0; e_oob3 = 0; e_lerr = 0;
  endtask

  task automatic capture();
    h_addr = ADDR; h_data = Data_in; h_ub = Mem_UB; h_lb = Mem_LB;
  endtask

  task automatic model_step();
    logic rd, wr, idle_b;
    logic [15:0] w;
    rd = !Mem_CE && Mem_WE && !Mem_OE;
    wr = !Mem_CE && !Mem_WE;
    idle_b = !wr_open && rd_run == 0;
    e_lerr = Load_en && !(idle_b && Mem_CE);
    if (Load_en && idle_b && Mem_CE) begin
      if (in_range(Load_addr)) mem_m[Load_addr[9:0]] = Load_data;
      else begin e_oob1 = 1; e_oob3 = 1; end
    end
    if (wr_open) begin
      if (wr) capture();
      else begin
        wr_open = 0;
        if (in_range(h_addr)) begin
          w = mem_m[h_addr[9:0]];
          if (!h_ub) w[15:8] = h_data[15:8];
          if (!h_lb) w[7:0]  = h_data[7:0];
          mem_m[h_addr[9:0]] = w;
        end else begin e_oob1 = 1; e_oob3 = 1; end
      end
      rd_run = 0;
    end else if (rd) begin
      if (rd_run > 0 && ADDR == last_addr) rd_run = (rd_run < 8) ? rd_run + 1 : 8;
      else rd_run = 1;
      last_addr = ADDR;
    end else begin
      if (rd_run == 0 && wr) begin wr_open = 1; capture(); end
      rd_run = 0;
    end
    w = 16'h0000;
    if (rd && in_range(ADDR)) begin
      w = mem_m[ADDR[9:0]];
      if (Mem_UB) w[15:8] = 8'h00;
      if (Mem_LB) w[7:0]  = 8'h00;
    end
    e_dv1 = rd_run >= 1;
    e_dv3 = rd_run >= 3;
    e_dout1 = e_dv1 ? w : 16'h0000;
    e_dout3 = e_dv3 ? w : 16'h0000;
    if (e_dv1 && !in_range(ADDR)) e_oob1 = 1;
    if (e_dv3 && !in_range(ADDR)) e_oob3 = 1;
  endtask

  always @(posedge Clk) begin
    if (Reset) model_reset();
    else model_step();
    #1;
    check("dout_l1", dout1, e_dout1);
    check("dv_l1",   dv1,   e_dv1);
    check("oob_l1",  oob1,  e_oob1);
    check("lerr_l1", lerr1, e_lerr);
    check("dout_l3", dout3, e_dout3);
    check("dv_l3",   dv3,   e_dv3);
    check("oob_l3",  oob3,  e_oob3);
    check("lerr_l3", lerr3, e_lerr);
  end

  task automatic drive(input logic ce, oe, we, ub, lb, input logic [15:0] a, d,
                       input logic le, input logic [15:0] la, ld);
    @(negedge Clk);
    Mem_CE = ce; Mem_OE = oe; Mem_WE = we; Mem_UB = ub; Mem_LB = lb;
    ADDR = a; Data_in = d; Load_en = le; Load_addr = la; Load_data = ld;
    @(posedge Clk);
    #3;
  endtask

  task automatic idle();
    drive(1, 1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
  endtask
  task automatic rd(input logic [15:0] a, input logic ub, lb);
    drive(0, 0, 1, ub, lb, a, 16'h0, 0, 16'h0, 16'h0);
  endtask
  task automatic wr(input logic [15:0] a, d, input logic ub, lb);
    drive(0, 1, 0, ub, lb, a, d, 0, 16'h0, 16'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) a = a | 16'h8000 | (16'($urandom_range(0, 31)) << 10);
    return a;
  endfunction

  initial begin
    logic [15:0] pd, a;
    int kind, len;
    Reset = 1'b1;
    Mem_CE = 1; Mem_OE = 1; Mem_WE = 1; Mem_UB = 0; Mem_LB = 0;
    ADDR = 0; Data_in = 0; Load_en = 0; Load_addr = 0; Load_data = 0;
    repeat (2) @(posedge Clk);
    #3;
    check("rst_dout", dout1, 16'h0000);
    check("rst_dv",   dv1,   1'b0);
    check("rst_oob",  oob1,  1'b0);
    check("rst_lerr", lerr1, 1'b0);
    @(negedge Clk) Reset = 1'b0;

    for (int i = 0; i < 1024; i++) begin
      case (i)
        0:       pd = 16'h0F0F;
        1:       pd = 16'h0111;
        2:       pd = 16'h0222;
        5:       pd = 16'h1234;
        'h10:    pd = 16'h5555;
        'h20:    pd = 16'h2020;
        'h30:    pd = 16'h3030;
        default: pd = 16'($urandom);
      endcase
      drive(1, 1, 1, 0, 0, 16'h0, 16'h0, 1, 16'(i), pd);
    end
    idle();

    rd(16'h0005, 0, 0);
    check("fetch1_dv", dv1, 1'b1);
    check("fetch1_data", dout1, 16'h1234);
    rd(16'h0005, 0, 0);
    check("fetch2_data", dout1, 16'h1234);
    idle();
    check("fetch_end_data", dout1, 16'h0000);
    check("fetch_end_dv", dv1, 1'b0);

    repeat (3) wr(16'h0010, 16'hABCD, 0, 1);
    idle();
    rd(16'h0010, 0, 0);
    check("wr_ub_only", dout1, 16'hAB55);
    idle();
    rd(16'h0010, 1, 0);
    check("rd_lb_only", dout1, 16'h0055);
    idle();
    drive(0, 0, 0, 1, 1, 16'h0010, 16'hFFFF, 0, 16'h0, 16'h0);
    check("we_oe_dv", dv1, 1'b0);
    idle();

    rd(16'h0001, 0, 0);
    rd(16'h0001, 0, 0);
    rd(16'h0002, 0, 0);
    rd(16'h0002, 0, 0);
    check("lat3_restart_dv", dv3, 1'b0);
    rd(16'h0002, 0, 0);
    check("lat3_dv", dv3, 1'b1);
    check("lat3_data", dout3, 16'h0222);
    idle();

    wr(16'h8000, 16'hFFFF, 0, 0);
    idle();
    check("oob_wr_l1", oob1, 1'b1);
    check("oob_wr_l3", oob3, 1'b1);
    drive(0, 1, 1, 0, 0, 16'h0, 16'h0, 1, 16'h0030, 16'hDEAD);
    check("load_rej", lerr1, 1'b1);
    idle();
    check("load_rej_pulse", lerr1, 1'b0);
    rd(16'h0030, 0, 0);
    check("load_rej_nowr", dout1, 16'h3030);
    rd(16'h0000, 0, 0);
    check("oob_nowr", dout1, 16'h0F0F);
    idle();
    check("oob_sticky", oob1, 1'b1);

    rd(16'h0005, 0, 0);
    #1 Reset = 1'b1;
    #1 check("async_rst_dv", dv1, 1'b0);
    @(negedge Clk) Reset = 1'b0;
    idle();
    wr(16'h0020, 16'hBEEF, 0, 0);
    #2 Reset = 1'b1;
    @(posedge Clk);
    #3;
    check("rst_wr_oob", oob1, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    Mem_CE = 1; Mem_WE = 1; Mem_OE = 1;
    idle();
    rd(16'h0020, 0, 0);
    check("rst_wr_abort", dout1, 16'h2020);
    idle();

    for (int n = 0; n < 700; n++) begin
      kind = $urandom_range(0, 9);
      a = rand_addr();
      if (n == 350) begin
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
      end
      case (kind)
        0, 1: idle();
        2, 3, 4, 5: begin
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 4) == 0) a = rand_addr();
            rd(a, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
          end
        end
        6, 7: begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++)
            wr(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        8: drive(1'($urandom_range(0, 3) != 0), 1, 1, 0, 0, 16'h0, 16'h0, 1, rand_addr(), 16'($urandom));
        default: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
                       1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      endcase
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/slc3_sram_responder.md
Name: slc3_sram_responder

Overview:
Memory-side responder for the SLC-3 external SRAM interface. It consumes the active-low strobes Mem_CE/OE/WE/UB/LB, the address and the write data driven by the CPU datapath and control unit, and returns read data with a fixed latency. The CPU's fetch sequence is two OE-low cycles, with MDR loading in the second. It serves as the on-chip memory in simulation and FPGA builds, and includes a preload port for program loading while the CPU is halted.

Parameters:
DEPTH_LOG2, 10, number of implemented word-address bits (1024 x 16 memory)
READ_LAT, 1, cycles from the edge that samples a read request to the cycle in which Data_out is valid; legal range 1..3

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
Mem_CE  in  1  chip enable, active low
Mem_OE  in  1  output enable, active low
Mem_WE  in  1  write enable, active low
Mem_UB  in  1  upper byte lane enable, active low
Mem_LB  in  1  lower byte lane enable, active low
ADDR  in  16  word address
Data_in  in  16  write data from the CPU
Data_out  out  16  read data to the CPU (MDR input)
Data_valid  out  1  Data_out holds valid read data this cycle
Load_en  in  1  preload write strobe, active high
Load_addr  in  16  preload address
Load_data  in  16  preload data
Oob_err  out  1  sticky flag: an out-of-range access occurred
Load_err  out  1  one-cycle pulse: Load_en was rejected

Behaviour:
- Reset: asynchronous, active-high, on Reset; clock Clk. On reset: state IDLE, Data_out = 16'h0000, Data_valid = 0, Oob_err = 0, Load_err = 0, latency counter = 0. Memory contents are not cleared.
- All strobes and address/data inputs are sampled at posedge Clk. The response is registered.
- Request decode on sampled values:
  - CE = 1: no request.
  - CE = 0 and WE = 0: write request. WE has priority over OE.
  - CE = 0, WE = 1, OE = 0: read request.
- States: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE.
- IDLE:
  - Read request: latch ADDR, load the counter with READ_LAT-1. Go to RD_DRIVE if READ_LAT = 1, otherwise to RD_WAIT.
  - Write request: go to WR_ACTIVE.
- RD_WAIT:
  - Decrement the counter; go to RD_DRIVE when it reaches 0.
  - If the read request drops, return to IDLE.
  - If ADDR differs from the latched address, re-latch and restart the count.
- RD_DRIVE:
  - Data_out = mem[addr] with lane masking: a disabled lane (UB or LB = 1) returns 8'h00 in that byte. Data_valid = 1.
  - Stay while the read request holds with the same address. An address change re-latches and re-enters the latency.
  - When the request drops, go to IDLE; Data_out returns to 16'h0000 and Data_valid to 0 in the same registered update.
- WR_ACTIVE:
  - Each cycle, capture ADDR, Data_in, UB and LB into a write-holding register.
  - The write commits exactly once, on the first edge at which WE or CE is sampled high. It uses the holding register, i.e. values from the last low cycle. Only enabled byte lanes are updated.
  - Then go to IDLE.
  - WE held low for N cycles still produces one commit.
- Out of range: ADDR[15:DEPTH_LOG2] != 0. Reads return 16'h0000 with Data_valid = 1; writes are discarded. Oob_err is set in either case and is cleared only by Reset.
- Reset during WR_ACTIVE: the write is aborted and memory is unchanged. Reset during a read drops Data_valid immediately (asynchronously).
- Preload:
  - Accepted only when state = IDLE and sampled CE = 1. Writes Load_data as a full word at Load_addr; out-of-range Load_addr sets Oob_err.
  - Otherwise the preload is ignored and Load_err pulses for one cycle.
  - A preload and a CPU request in the same cycle: the CPU wins and the load is rejected.
- Read-after-write: a read issued in the cycle after a commit returns the new data (no bypass needed, since the commit precedes the read sample).

Decomposition:
- Add to lc3b_types:
  - enum mem_state_t {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE}
  - constant MEM_ASSERT = 1'b0 (strobe polarity)
  - constant MEM_DEFAULT_DEPTH_LOG2 = 10
- One sub-module: slc3_sram_array. It holds 2^DEPTH_LOG2 x 16 storage with a synchronous write port carrying 2-bit byte enables and a combinational read port; the responder registers the output.
- The FSM, latency counter, holding register and error flags stay in the top module.

Test Plan:
- Preload 16'h1234 at address 0x0005 with CE = 1, then 2-cycle CE = 0/OE = 0 at 0x0005 -> Data_out = 16'h1234 and Data_valid = 1 in the second cycle (READ_LAT = 1); Data_out = 0 once OE rises.
- Write 16'hABCD at 0x0010 with WE low for 3 cycles and UB = 0, LB = 1, over prior content 16'h5555 -> exactly one commit; a read returns 16'hAB55.
- Read 0x0010 with UB = 1, LB = 0 -> 16'h0055. Read with WE = 0 and OE = 0 together -> treated as a write, Data_valid stays 0.
- READ_LAT = 3: the address changes from 0x0001 to 0x0002 in the second wait cycle -> latency restarts; valid data for 0x0002 appears 3 cycles after the change.
- Write to 0x8000 -> memory unchanged, Oob_err = 1 and stays 1 until Reset. Load_en while CE = 0 -> Load_err pulses for one cycle, no write.
- Assert Reset in the second WE-low cycle of a write to 0x0020 -> no commit, the old value is read back, all outputs return to reset values.
